// File: rtl/multi_input_sanitizer.sv
// Per-channel two-flop synchroniser, counter-based debouncer and edge-pulse generator.
// Debounced level changes only after STABLE_CYCLES consecutive enabled cycles of disagreement.
module multi_input_sanitizer #(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MODE          = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] pulse_o,
  output logic         any_o
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [N-1:0]           s1_q, s2_q;
  logic [N-1:0]           level_q, level_d;
  logic [N-1:0]           rise_q, rise_d;
  logic [N-1:0]           fall_q, fall_d;
  logic [N-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    if (en_i) begin
      for (int i = 0; i < N; i++) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_d[i]   = '0;
          level_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Synchronisers keep sampling even while en_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= in_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unsupported MODE values fall back to rising-edge pulses.
  always_comb begin
    if (MODE == 1) begin
      pulse_o = fall_q;
    end else if (MODE == 2) begin
      pulse_o = rise_q | fall_q;
    end else begin
      pulse_o = rise_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign any_o   = |pulse_o;

endmodule

// File: tb/tb_multi_input_sanitizer.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run
// compared against a history-based reference model.
module tb_multi_input_sanitizer;
  localparam int unsigned N    = 4;
  localparam int unsigned S    = 4;
  localparam int unsigned MODE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] in_v;
  logic [N-1:0] level, rise, fall, pulse;
  logic         any_v;

  always #5 clk = ~clk;

  multi_input_sanitizer #(
    .N            (N),
    .STABLE_CYCLES(S),
    .MODE         (MODE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .in_i   (in_v),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall),
    .pulse_o(pulse),
    .any_o  (any_v)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a level flips once the last S synchronised samples seen on
  // enabled edges (since its previous flip) all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic [N-1:0] m_hist[$];
  int           m_flip[N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    m_hist.delete();
    for (int i = 0; i < N; i++) m_flip[i] = 0;
  endtask

  task automatic model_edge(input logic e, input logic [N-1:0] v);
    logic [N-1:0] seen;
    int           sz;
    bit           all_diff;
    seen   = m_s2;
    m_s2   = m_s1;
    m_s1   = v;
    m_rise = '0;
    m_fall = '0;
    if (e) begin
      m_hist.push_back(seen);
      sz = m_hist.size();
      for (int i = 0; i < N; i++) begin
        if (sz - m_flip[i] >= int'(S)) begin
          all_diff = 1'b1;
          for (int k = 1; k <= int'(S); k++)
            if (m_hist[sz-k][i] == m_lvl[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
            m_flip[i] = sz;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] p;
    p = m_rise | m_fall;
    check({tag, " level"}, level, m_lvl);
    check({tag, " rise"},  rise,  m_rise);
    check({tag, " fall"},  fall,  m_fall);
    check({tag, " pulse"}, pulse, p);
    check({tag, " any"},   {{(N-1){1'b0}}, any_v}, {{(N-1){1'b0}}, |p});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " level"}, level, '0);
    check({tag, " rise"},  rise,  '0);
    check({tag, " fall"},  fall,  '0);
    check({tag, " pulse"}, pulse, '0);
    check({tag, " any"},   {{(N-1){1'b0}}, any_v}, '0);
  endtask

  // Apply inputs ahead of the next rising edge, then sample 1 time unit after it.
  task automatic step(input logic e, input logic [N-1:0] v);
    en   = e;
    in_v = v;
    @(posedge clk);
    model_edge(e, v);
    #1;
  endtask

  // Called 1 unit after a rising edge; reset pulse finishes well before the next edge.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_zero(tag);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic [N-1:0] in;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  vec_t         tbl[$];
  logic [N-1:0] cur, pexp, cap;
  int           cnt, at;

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    in_v  = '0;
    @(posedge clk);
    do_reset("init");

    // Clean press then clean release on channel 0 (edge E0 is the first row).
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1'b1, 4'b0001, (k >= 5) ? 4'b0001 : 4'b0000,
                      (k == 5) ? 4'b0001 : 4'b0000, 4'b0000});
    for (int k = 10; k < 17; k++)
      tbl.push_back('{1'b1, 4'b0000, (k >= 15) ? 4'b0000 : 4'b0001, 4'b0000,
                      (k == 15) ? 4'b0001 : 4'b0000});
    for (int j = 0; j < tbl.size(); j++) begin
      step(tbl[j].en, tbl[j].in);
      pexp = tbl[j].rise | tbl[j].fall;
      check($sformatf("tbl[%0d] level", j), level, tbl[j].lvl);
      check($sformatf("tbl[%0d] rise", j),  rise,  tbl[j].rise);
      check($sformatf("tbl[%0d] fall", j),  fall,  tbl[j].fall);
      check($sformatf("tbl[%0d] pulse", j), pulse, pexp);
      check($sformatf("tbl[%0d] any", j),   {3'b000, any_v}, {3'b000, |pexp});
    end

    // Bounce on channel 1: high 3, low 1, then held high.
    do_reset("rst bounce");
    cnt = 0; at = -1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k == 3) ? 4'b0000 : 4'b0010);
      check_model($sformatf("bounce k%0d", k));
      if (rise[1]) begin cnt++; at = k; end
    end
    check_int("bounce rise count", cnt, 1);
    check_int("bounce rise edge", at, 9);

    // Two channels together with en low for two cycles mid-count.
    do_reset("rst enable");
    cnt = 0; at = -1; cap = '0;
    for (int k = 0; k < 14; k++) begin
      step(!(k == 3 || k == 4), 4'b1010);
      check_model($sformatf("enable k%0d", k));
      if (pulse != 0) begin cnt++; at = k; cap = rise; end
    end
    check_int("enable pulse count", cnt, 1);
    check_int("enable pulse edge", at, 7);
    check("enable rise value", cap, 4'b1010);

    // Half-cycle async reset while all levels are high, input held high.
    do_reset("rst async");
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111);
    check("async pre level", level, 4'b1111);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_zero("async mid");
    #4 rst_n = 1'b1;
    cnt = 0; at = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'b1111);
      check_model($sformatf("async k%0d", k));
      if (rise == 4'b1111) begin cnt++; at = k; end
    end
    check_int("async rise count", cnt, 1);
    check_int("async rise edge", at, 5);

    // Reset mid-count discards progress; reset during a pulse ends it at once.
    do_reset("rst midcount");
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0100);
    do_reset("midcount");
    at = -1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'b0100);
      check_model($sformatf("midcount k%0d", k));
      if (rise[2]) at = k;
    end
    check_int("midcount rise edge", at, 5);
    check("pulse before reset", rise, 4'b0100);
    do_reset("during pulse");

    // Randomized run against the model.
    cur = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      step($urandom_range(0, 9) != 0, cur);
      check_model($sformatf("rand k%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_input_sanitizer.md
MULTI_INPUT_SANITIZER -- requirements
Module: multi_input_sanitizer

Interface
REQ-001 Parameter N, default 4: number of independent input channels, N >= 1.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive cycles a synchronised input must differ from the debounced level before the level changes, STABLE_CYCLES >= 1.
REQ-003 Parameter MODE, default 0: pulse source select; 0 = rising edge, 1 = falling edge, 2 = both edges.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: global enable; when low, all debouncing is frozen and pulses are suppressed.
REQ-007 Port in, input, N: raw, possibly asynchronous and bouncing, per-channel inputs.
REQ-008 Port level, output, N: debounced registered level per channel.
REQ-009 Port rise, output, N: one-cycle pulse per channel on a debounced 0->1 change.
REQ-010 Port fall, output, N: one-cycle pulse per channel on a debounced 1->0 change.
REQ-011 Port pulse, output, N: the rise or fall pulse, or both, per channel as selected by MODE.
REQ-012 Port any, output, 1: OR-reduction of pulse.

Function
REQ-013 Each channel SHALL pass in[i] through a two-flop synchroniser (s1, s2) before any other use.
REQ-014 Each channel SHALL hold a counter of width clog2(STABLE_CYCLES), minimum 1 bit.
REQ-015 Per edge with en high and s2[i] == level[i]: counter cleared to 0; level, rise and fall for that channel stay low or unchanged.
REQ-016 Per edge with en high, s2[i] != level[i] and counter < STABLE_CYCLES-1: counter increments.
REQ-017 Per edge with en high, s2[i] != level[i] and counter == STABLE_CYCLES-1: level[i] toggles and the counter clears; rise[i] is set if the new level is 1, otherwise fall[i] is set.
REQ-018 rise and fall SHALL be registered and high for exactly one cycle, the first cycle in which level shows its new value.
REQ-019 Latency: input set up before edge E0 and held SHALL flip level and pulse at edge E(STABLE_CYCLES+1).
REQ-020 A deviation lasting fewer than STABLE_CYCLES synchronised cycles SHALL produce no level change and no pulse.
REQ-021 Holding an input at a constant value SHALL produce no further pulses after the first.
REQ-022 pulse = rise (MODE 0), fall (MODE 1), rise|fall (MODE 2); combinational from registered rise and fall.
REQ-023 When en is low: counters hold their values; level holds its value; rise and fall are forced to 0 on the next edge; synchronisers keep sampling.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulse in the same cycle.
REQ-025 MODE values other than 0-2 SHALL behave as MODE 0.

Reset
REQ-026 When reset is low: s1, s2, counters, level, rise and fall are cleared to 0 immediately, independent of clk.
REQ-027 Asserting reset mid-count SHALL discard the count; asserting it during a pulse cycle SHALL end the pulse at once.
REQ-028 After reset release, an input already high SHALL be treated as a new 0->1 change and produce one rise after the REQ-019 latency.

Verification
REQ-029 Scenarios use N=4, STABLE_CYCLES=4, MODE=2.
REQ-030 Clean press: in=0001 set before E0 and held 10 cycles -> level[0]=1 and rise=0001, pulse=0001, any=1 for one cycle at E5; no further pulses.
REQ-031 Clean release: in returns to 0000 after REQ-030 -> fall=0001 for one cycle 5 edges later; level=0000.
REQ-032 Bounce: in[1] high for 3 cycles, low for 1 cycle, then high and held -> exactly one rise[1], 5 edges after the final rising transition; none earlier.
REQ-033 Simultaneous events and enable: in=1010 with en dropped low for 2 cycles mid-count -> pulse delayed by 2 cycles; rise=1010 in a single cycle.
REQ-034 Async reset: reset low for a half-cycle between edges while level=1111 -> all outputs 0 before the next edge; with in held at 1111 after release -> one rise=1111 at E5.
